// File: rtl/cpu_defs_pkg.sv
// Shared CPU datapath definitions: register-file geometry and the write
// request record used between the writeback arbiter and its external queue.
package cpu_defs_pkg;

  localparam int REG_ADDR_W              = 4;
  localparam int DATA_W                  = 32;
  localparam int RF_STARVE_LIMIT_DEFAULT = 8;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } rf_wr_t;

endpackage

// File: rtl/rf_ext_fifo.sv
// Circular queue of pending external register writes. Each slot carries its
// own valid bit so stale entries can be cancelled in place by address match.
module rf_ext_fifo
  import cpu_defs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  rf_wr_t                    push_ent,
  input  logic                      pop,
  input  logic                      cancel_en,
  input  logic [REG_ADDR_W-1:0]     cancel_addr,
  output rf_wr_t                    head,
  output logic                      any_valid,
  output logic                      cancel_hit,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [DEPTH-1:0]      vld;
  logic [DEPTH-1:0]      vld_nxt;
  logic [DEPTH-1:0]      hit;
  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];

  // Cancellation only sees registered slots, so a same-cycle push survives.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = cancel_en && vld[i] && (addr_q[i] == cancel_addr);
    end
    vld_nxt = vld & ~hit;
    if (pop)  vld_nxt[rd_ptr] = 1'b0;
    if (push) vld_nxt[wr_ptr] = 1'b1;
  end

  assign cancel_hit = |hit;
  assign any_valid  = |vld;
  assign head.valid = vld[rd_ptr];
  assign head.addr  = addr_q[rd_ptr];
  assign head.data  = data_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      vld    <= '0;
      count  <= '0;
    end else begin
      vld <= vld_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_ent.addr;
      data_q[wr_ptr] <= push_ent.data;
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: writeback has absolute priority, queued
// external writes fill idle slots, with starvation stall and drained-halt status.
module rf_wport_arbiter
  import cpu_defs_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = RF_STARVE_LIMIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_we,
  input  logic [REG_ADDR_W-1:0]     wb_waddr,
  input  logic [DATA_W-1:0]         wb_wdata,
  input  logic                      wb_halted,
  input  logic                      ext_valid,
  output logic                      ext_ready,
  input  logic [REG_ADDR_W-1:0]     ext_waddr,
  input  logic [DATA_W-1:0]         ext_wdata,
  output logic                      rf_we,
  output logic [REG_ADDR_W-1:0]     rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      stall_req,
  output logic                      ext_dropped,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      halted
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  rf_wr_t          push_ent;
  rf_wr_t          head;
  logic            push;
  logic            pop;
  logic            present;
  logic            head_write;
  logic            blocked;
  logic            any_valid;
  logic            cancel_hit;
  logic            halt_seen;
  logic            stall_set;
  logic [SC_W-1:0] starve_cnt;

  assign ext_ready = (fifo_count < CNT_W'(DEPTH));
  assign push      = ext_valid && ext_ready;
  assign push_ent  = '{valid: 1'b1, addr: ext_waddr, data: ext_wdata};

  assign present    = (fifo_count != '0);
  assign head_write = !wb_we && present && head.valid;
  assign blocked    = wb_we && present && head.valid;
  // Cancelled heads are retired silently even while WB owns the port.
  assign pop        = present && (!head.valid || head_write);

  rf_ext_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_ent    (push_ent),
    .pop         (pop),
    .cancel_en   (wb_we),
    .cancel_addr (wb_waddr),
    .head        (head),
    .any_valid   (any_valid),
    .cancel_hit  (cancel_hit),
    .count       (fifo_count)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wb_waddr;
    rf_wdata = '0;
    if (wb_we) begin
      rf_we    = 1'b1;
      rf_wdata = wb_wdata;
    end else if (head_write) begin
      rf_we    = 1'b1;
      rf_waddr = head.addr;
      rf_wdata = head.data;
    end
    rf_we = rf_we && rst_n;
  end

  // Registered stall: arm one cycle early so it is visible on blocked cycle STARVE_LIMIT.
  assign stall_set = blocked && ((int'(starve_cnt) + 1) >= (STARVE_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt  <= '0;
      stall_req   <= 1'b0;
      ext_dropped <= 1'b0;
      halt_seen   <= 1'b0;
    end else begin
      ext_dropped <= cancel_hit;
      if (wb_halted) halt_seen <= 1'b1;
      if (head_write || !any_valid) begin
        starve_cnt <= '0;
        stall_req  <= 1'b0;
      end else if (blocked) begin
        if (starve_cnt != SC_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
        if (stall_set) stall_req <= 1'b1;
      end
    end
  end

  assign halted = halt_seen && !present && !ext_valid;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter with a shadow regfile built from rf_* writes.
module tb_rf_wport_arbiter;
  import cpu_defs_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0]     wb_wdata;
  logic                  wb_halted;
  logic                  ext_valid;
  logic                  ext_ready;
  logic [REG_ADDR_W-1:0] ext_waddr;
  logic [DATA_W-1:0]     ext_wdata;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  stall_req;
  logic                  ext_dropped;
  logic [2:0]            fifo_count;
  logic                  halted;

  logic [DATA_W-1:0] regs [16];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we) regs[rf_waddr] <= rf_wdata;

  rf_wport_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_halted(wb_halted),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .ext_dropped(ext_dropped), .fifo_count(fifo_count), .halted(halted)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic hlt, input logic ev, input logic [3:0] ea, input logic [31:0] ed);
    wb_we = we; wb_waddr = wa; wb_wdata = wd; wb_halted = hlt;
    ext_valid = ev; ext_waddr = ea; ext_wdata = ed;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 5, 32'd7, 0, 0, 0, 0);
    next_cycle(); settle();
    total++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d exp 0", fifo_count); else passed++;
    total++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got %b exp 0", rf_we); else passed++;
    total++; if (stall_req !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall_req); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else passed++;
    total++; if (ext_dropped !== 1'b0) $display("FAIL reset_dropped got %b exp 0", ext_dropped); else passed++;
    total++; if (ext_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", ext_ready); else passed++;
    next_cycle();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_single();
    next_cycle(); drive(0, 0, 0, 0, 1, 3, 32'hA5A5_0001); settle();
    total++; if (ext_ready !== 1'b1) $display("FAIL single_ready got %b exp 1", ext_ready); else passed++;
    total++; if (rf_we !== 1'b0) $display("FAIL single_idle_we got %b exp 0", rf_we); else passed++;
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0); settle();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 4'd3 || rf_wdata !== 32'hA5A5_0001)
      $display("FAIL single_write got we=%b a=%0d d=%h exp we=1 a=3 d=a5a50001", rf_we, rf_waddr, rf_wdata); else passed++;
    total++; if (fifo_count !== 3'd1) $display("FAIL single_count1 got %0d exp 1", fifo_count); else passed++;
    next_cycle(); settle();
    total++; if (fifo_count !== 3'd0 || rf_we !== 1'b0)
      $display("FAIL single_drained got cnt=%0d we=%b exp cnt=0 we=0", fifo_count, rf_we); else passed++;
    total++; if (rf_wdata !== 32'd0) $display("FAIL single_idle_data got %h exp 0", rf_wdata); else passed++;
  endtask

  task automatic test_starve();
    next_cycle(); drive(1, 5, 32'd7, 0, 1, 6, 32'd9); settle();
    total++; if (rf_waddr !== 4'd5 || rf_wdata !== 32'd7)
      $display("FAIL starve_wb0 got a=%0d d=%0d exp a=5 d=7", rf_waddr, rf_wdata); else passed++;
    for (int k = 1; k <= 8; k++) begin
      next_cycle(); drive(1, 5, 32'd7, 0, 0, 0, 0); settle();
      total++; if (rf_we !== 1'b1 || rf_waddr !== 4'd5 || rf_wdata !== 32'd7)
        $display("FAIL starve_wb%0d got we=%b a=%0d d=%0d exp we=1 a=5 d=7", k, rf_we, rf_waddr, rf_wdata); else passed++;
      total++; if (stall_req !== (k == 8))
        $display("FAIL starve_stall%0d got %b exp %b", k, stall_req, (k == 8)); else passed++;
    end
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0); settle();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 4'd6 || rf_wdata !== 32'd9)
      $display("FAIL starve_release got we=%b a=%0d d=%0d exp we=1 a=6 d=9", rf_we, rf_waddr, rf_wdata); else passed++;
    total++; if (stall_req !== 1'b1) $display("FAIL starve_hold got %b exp 1", stall_req); else passed++;
    next_cycle(); settle();
    total++; if (stall_req !== 1'b0) $display("FAIL starve_clear got %b exp 0", stall_req); else passed++;
    total++; if (fifo_count !== 3'd0) $display("FAIL starve_count got %0d exp 0", fifo_count); else passed++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      next_cycle(); drive(1, 1, 32'h100, 0, 1, 4'(8 + i), 32'h80 + i); settle();
      total++; if (ext_ready !== 1'b1 || fifo_count !== 3'(i))
        $display("FAIL fill_push%0d got rdy=%b cnt=%0d exp rdy=1 cnt=%0d", i, ext_ready, fifo_count, i); else passed++;
    end
    next_cycle(); drive(1, 1, 32'h100, 0, 1, 12, 32'hEE); settle();
    total++; if (fifo_count !== 3'd4 || ext_ready !== 1'b0)
      $display("FAIL fill_full got cnt=%0d rdy=%b exp cnt=4 rdy=0", fifo_count, ext_ready); else passed++;
    next_cycle(); settle();
    total++; if (fifo_count !== 3'd4) $display("FAIL fill_no_overflow got %0d exp 4", fifo_count); else passed++;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); drive(0, 0, 0, 0, 0, 0, 0); settle();
      total++; if (rf_we !== 1'b1 || rf_waddr !== 4'(8 + i) || rf_wdata !== 32'h80 + i || fifo_count !== 3'(4 - i))
        $display("FAIL fill_drain%0d got we=%b a=%0d d=%h cnt=%0d exp we=1 a=%0d d=%h cnt=%0d",
                 i, rf_we, rf_waddr, rf_wdata, fifo_count, 8 + i, 32'h80 + i, 4 - i); else passed++;
    end
    next_cycle(); drive(0, 0, 0, 0, 1, 13, 32'h90); settle();
    total++; if (fifo_count !== 3'd0 || rf_we !== 1'b0)
      $display("FAIL fill_empty got cnt=%0d we=%b exp cnt=0 we=0", fifo_count, rf_we); else passed++;
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0); settle();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 4'd13 || rf_wdata !== 32'h90)
      $display("FAIL fill_wrap got we=%b a=%0d d=%h exp we=1 a=13 d=90", rf_we, rf_waddr, rf_wdata); else passed++;
    next_cycle(); settle();
  endtask

  task automatic test_cancel();
    next_cycle(); drive(1, 7, 32'h33, 0, 1, 2, 32'h11); settle();
    next_cycle(); drive(1, 2, 32'h22, 0, 0, 0, 0); settle();
    total++; if (rf_waddr !== 4'd2 || rf_wdata !== 32'h22)
      $display("FAIL cancel_wb got a=%0d d=%h exp a=2 d=22", rf_waddr, rf_wdata); else passed++;
    total++; if (ext_dropped !== 1'b0) $display("FAIL cancel_early_drop got %b exp 0", ext_dropped); else passed++;
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0); settle();
    total++; if (ext_dropped !== 1'b1) $display("FAIL cancel_drop got %b exp 1", ext_dropped); else passed++;
    total++; if (rf_we !== 1'b0 || fifo_count !== 3'd1)
      $display("FAIL cancel_silent got we=%b cnt=%0d exp we=0 cnt=1", rf_we, fifo_count); else passed++;
    next_cycle(); settle();
    total++; if (fifo_count !== 3'd0 || ext_dropped !== 1'b0)
      $display("FAIL cancel_after got cnt=%0d drop=%b exp cnt=0 drop=0", fifo_count, ext_dropped); else passed++;
    total++; if (regs[2] !== 32'h22) $display("FAIL cancel_r2 got %h exp 22", regs[2]); else passed++;
    next_cycle(); drive(1, 4, 32'h44, 0, 1, 4, 32'h55); settle();
    total++; if (rf_wdata !== 32'h44) $display("FAIL samecyc_wb got %h exp 44", rf_wdata); else passed++;
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0); settle();
    total++; if (rf_we !== 1'b1 || rf_waddr !== 4'd4 || rf_wdata !== 32'h55 || ext_dropped !== 1'b0)
      $display("FAIL samecyc_keep got we=%b a=%0d d=%h drop=%b exp we=1 a=4 d=55 drop=0",
               rf_we, rf_waddr, rf_wdata, ext_dropped); else passed++;
    next_cycle(); settle();
  endtask

  task automatic test_halt();
    next_cycle(); drive(1, 1, 32'h1, 0, 1, 8, 32'd1); settle();
    total++; if (halted !== 1'b0) $display("FAIL halt_pre got %b exp 0", halted); else passed++;
    next_cycle(); drive(1, 1, 32'h1, 1, 1, 9, 32'd2); settle();
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0); settle();
    total++; if (halted !== 1'b0 || fifo_count !== 3'd2 || rf_waddr !== 4'd8 || rf_wdata !== 32'd1)
      $display("FAIL halt_drain1 got h=%b cnt=%0d a=%0d d=%0d exp h=0 cnt=2 a=8 d=1",
               halted, fifo_count, rf_waddr, rf_wdata); else passed++;
    next_cycle(); settle();
    total++; if (halted !== 1'b0 || rf_waddr !== 4'd9 || rf_wdata !== 32'd2)
      $display("FAIL halt_drain2 got h=%b a=%0d d=%0d exp h=0 a=9 d=2", halted, rf_waddr, rf_wdata); else passed++;
    next_cycle(); settle();
    total++; if (halted !== 1'b1) $display("FAIL halt_set got %b exp 1", halted); else passed++;
    next_cycle(); settle();
    total++; if (halted !== 1'b1) $display("FAIL halt_sticky got %b exp 1", halted); else passed++;
    next_cycle(); drive(0, 0, 0, 0, 1, 10, 32'd3); settle();
    total++; if (halted !== 1'b0 || ext_ready !== 1'b1)
      $display("FAIL halt_extreq got h=%b rdy=%b exp h=0 rdy=1", halted, ext_ready); else passed++;
    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0); settle();
    total++; if (halted !== 1'b0 || rf_waddr !== 4'd10 || rf_wdata !== 32'd3)
      $display("FAIL halt_late got h=%b a=%0d d=%0d exp h=0 a=10 d=3", halted, rf_waddr, rf_wdata); else passed++;
    next_cycle(); settle();
    total++; if (halted !== 1'b1) $display("FAIL halt_reset got %b exp 1", halted); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      next_cycle(); drive(1, 1, 32'h5, 0, 1, 4'(12 + i), 32'hC0 + i); settle();
    end
    next_cycle(); drive(1, 1, 32'h5, 0, 0, 0, 0); settle();
    total++; if (fifo_count !== 3'd3) $display("FAIL rstmid_pre got %0d exp 3", fifo_count); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (fifo_count !== 3'd0 || rf_we !== 1'b0 || halted !== 1'b0)
      $display("FAIL rstmid_async got cnt=%0d we=%b h=%b exp 0 0 0", fifo_count, rf_we, halted); else passed++;
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      settle();
      total++; if (rf_we !== 1'b0 || fifo_count !== 3'd0)
        $display("FAIL rstmid_post%0d got we=%b cnt=%0d exp we=0 cnt=0", i, rf_we, fifo_count); else passed++;
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_starve();
    test_fill();
    test_cancel();
    test_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between the CPU writeback path and an external return path. The external path carries cache-fill or mini-GPU results on a valid/ready handshake.
- WB writes always win and pass through with zero latency. External writes queue in a small FIFO and drain in cycles where WB is not writing.
- Provides anti-starvation stall back-pressure to the pipeline, stale-entry cancellation, and a drained-halt indication.

Parameters:
- DEPTH, 4, external FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 8, consecutive blocked cycles before stall_req asserts (>=1)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- wb_we  input  1  WB write enable
- wb_waddr  input  4  WB destination register
- wb_wdata  input  32  WB write data
- wb_halted  input  1  WB retired HALT this cycle
- ext_valid  input  1  external write request
- ext_ready  output  1  FIFO can accept
- ext_waddr  input  4  external destination register
- ext_wdata  input  32  external write data
- rf_we  output  1  regfile write enable
- rf_waddr  output  4  regfile write address
- rf_wdata  output  32  regfile write data
- stall_req  output  1  request upstream pipeline freeze
- ext_dropped  output  1  one-cycle pulse: an external write was cancelled as stale
- fifo_count  output  $clog2(DEPTH)+1  occupancy
- halted  output  1  HALT seen and external traffic drained

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset values: FIFO empty, fifo_count=0, stall_req=0, halted=0, ext_dropped=0, wait counter=0, halt_seen=0. rf_we is forced 0 while rst_n=0.
- ext_ready = (fifo_count < DEPTH). Registered-only decision; there is no same-cycle pop bypass.
- Enqueue occurs when ext_valid && ext_ready. The entry is stored with its valid bit set.
- Port mux (combinational):
  - wb_we=1: rf_we=1, rf_waddr/rf_wdata from WB.
  - Otherwise, if the head is valid: rf_we=1, rf_waddr/rf_wdata from the head, and the head pops.
  - Otherwise: rf_we=0, rf_waddr=wb_waddr, rf_wdata=0.
- Invalid head: popped silently in any cycle, including cycles with wb_we=1, with rf_we unaffected.
- Stale cancel: when wb_we=1, every queued entry with addr==wb_waddr has its valid bit cleared. ext_dropped pulses on the next cycle if at least one entry was cleared. The cancel check uses registered entries only; an entry enqueued in the same cycle is not cancelled.
- Simultaneous enqueue and pop: fifo_count is unchanged; pointers wrap modulo DEPTH.
- Starvation:
  - Counter increments each cycle a valid head exists and wb_we=1.
  - Clears when a valid head is written or the FIFO holds no valid entry.
  - stall_req is a register: set when the counter reaches STARVE_LIMIT-1 while still blocked, so it is high from cycle STARVE_LIMIT of blocking. Cleared the cycle after the starved head is written.
  - wb_we remaining 1 while stall_req=1 is legal, since in-flight instructions drain; the arbiter keeps waiting.
- Halt:
  - halt_seen is sticky, set on wb_halted.
  - halted = halt_seen && fifo_count==0 && !ext_valid (combinational on the registered state).
  - External writes are still accepted after halt.
- Reset asserted mid-operation discards all queued entries with no write.

Decomposition:
- cpu_defs_pkg gains:
  - REG_ADDR_W=4 and DATA_W=32 constants;
  - an rf_wr_t struct {valid, addr, data};
  - RF_STARVE_LIMIT_DEFAULT.
- One sub-module, rf_ext_fifo: a circular buffer with per-entry valid bits, an address-match cancel port, and a count output. The arbiter top holds the mux, starvation counter and halt logic.

Test Plan:
- Idle WB, ext writes r3=0xA5A5_0001: ext_ready=1, enqueue cycle N, rf_we=1 with r3/0xA5A5_0001 at cycle N+1, fifo_count back to 0.
- WB writes r5=7 every cycle while ext queues r6=9: rf_* shows WB only, and stall_req rises at the 8th blocked cycle. Drop wb_we: r6=9 is written and stall_req=0 the following cycle.
- Fill 4 ext entries under continuous WB: ext_ready=0 at fifo_count=4. Release WB: 4 writes in order, no overflow, wrap on the next enqueue.
- Queue ext r2=0x11, then WB writes r2=0x22: ext_dropped pulses, the entry pops with no write, and regfile r2 ends at 0x22.
- wb_halted with 2 ext entries queued: halted=0 until both are written, then halted=1 and stays high.
- Assert rst_n=0 with 3 queued entries: fifo_count=0, rf_we=0, and no stale writes after release.
